rv_hostcall_resp: RTL and testbench

- Memory-mapped responder for core-initiated host calls. The RV32 core writes arguments and then a syscall number (a7-style) into a small mailbox.
- The block services the call, returns a result code and raises status flags.
- Sits on the core's data bus as a peripheral. Core firmware implements ecall/exit/putchar through it, so simulation and hardware end runs without probing core internals.
- Supports SYS_exit (93), SYS_write (64) with packed byte payload, and unknown-call rejection.

---
 rtl/rv_hostcall_resp_pkg.sv | 45 ++++
 rtl/rv_hostcall_resp_txq.sv | 81 ++++++++
 rtl/rv_hostcall_resp.sv | 152 +++++++++++++++
 tb/tb_rv_hostcall_resp.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_hostcall_resp_pkg.sv
// Shared types for the host-call mailbox: syscall numbers, register map,
// FSM states and the STATUS bit layout.
package rv_hostcall_resp_pkg;

  localparam int          DATA_W         = 32;
  localparam logic [31:0] SYS_EXIT_NUM   = 32'd93;
  localparam logic [31:0] SYS_WRITE_NUM  = 32'd64;
  localparam logic [31:0] ENOSYS_VAL     = 32'hFFFF_FFDA;
  localparam int          TX_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ADR_CMD    = 3'd0,
    ADR_ARG0   = 3'd1,
    ADR_ARG1   = 3'd2,
    ADR_ARG2   = 3'd3,
    ADR_STATUS = 3'd4,
    ADR_RET    = 3'd5
  } reg_adr_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_SEND,
    ST_DONE
  } hc_state_e;

  typedef struct packed {
    logic ovr;
    logic tmo;
    logic exit_req;
    logic busy;
  } status_t;

  function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old,
                                                 input logic [DATA_W-1:0] wd,
                                                 input logic [3:0]        be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rv_hostcall_resp_txq.sv
// Byte sequencer for SYS_write: walks the payload word little-endian,
// holds each byte under backpressure and aborts on a per-byte timeout.
module rv_hostcall_resp_txq
  import rv_hostcall_resp_pkg::*;
#(
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        len,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              done,
  output logic              timeout,
  output logic [2:0]        sent
);

  localparam int CNT_W = $clog2(TX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TX_TIMEOUT - 1);

  logic [DATA_W-1:0] data_q;
  logic [2:0]        len_q;
  logic [1:0]        idx;
  logic [CNT_W-1:0]  cnt;
  logic              last;
  logic              expire;

  function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] d, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

  assign last    = ({1'b0, idx} == (len_q - 3'd1));
  assign expire  = (cnt == CNT_MAX);
  assign done    = tx_valid && ((tx_ready && last) || (!tx_ready && expire));
  assign timeout = tx_valid && !tx_ready && expire;
  assign sent    = timeout ? {1'b0, idx} : len_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      len_q    <= '0;
      idx      <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (start) begin
      data_q   <= data;
      len_q    <= len;
      idx      <= '0;
      cnt      <= '0;
      tx_valid <= 1'b1;
      tx_data  <= data[7:0];
    end else if (tx_valid) begin
      if (tx_ready) begin
        cnt <= '0;
        if (last) begin
          tx_valid <= 1'b0;
        end else begin
          idx     <= idx + 2'd1;
          tx_data <= byte_sel(data_q, idx + 2'd1);
        end
      end else if (expire) begin
        tx_valid <= 1'b0;
      end else begin
        // stalled: data and valid hold, only the timeout counter moves
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rv_hostcall_resp.sv
// Host-call mailbox peripheral: single-cycle register bus, syscall dispatch
// FSM for exit/write/unknown, sticky status flags.
module rv_hostcall_resp
  import rv_hostcall_resp_pkg::*;
#(
  parameter logic [31:0] SYS_EXIT   = SYS_EXIT_NUM,
  parameter logic [31:0] SYS_WRITE  = SYS_WRITE_NUM,
  parameter logic [31:0] ENOSYS_RET = ENOSYS_VAL,
  parameter int          TX_TIMEOUT = TX_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic [3:0]        we,
  input  logic [2:0]        adr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              exit_req,
  output logic [DATA_W-1:0] exit_code
);

  hc_state_e         state, state_n;
  logic [DATA_W-1:0] cmd_q, arg0_q, arg1_q, arg2_q;
  logic [DATA_W-1:0] snap0, snap1, snap2;
  logic [DATA_W-1:0] ret_q;
  logic [DATA_W-1:0] rd_mux;
  logic              ovr, tmo, busy;
  logic              wr_en, rd_en, cmd_wr, stat_rd, start;
  logic              tx_done, tx_tmo;
  logic [2:0]        tx_sent;
  logic [2:0]        wr_len;
  status_t           st;

  // Payload length saturates at one word's worth of bytes.
  function automatic logic [2:0] sat_len(input logic [DATA_W-1:0] v);
    return (v > 32'd4) ? 3'd4 : v[2:0];
  endfunction

  assign busy    = (state != ST_IDLE);
  assign wr_en   = cs && (we != 4'b0);
  assign rd_en   = cs && (we == 4'b0);
  assign cmd_wr  = wr_en && (adr == ADR_CMD);
  assign stat_rd = rd_en && (adr == ADR_STATUS);
  assign wr_len  = sat_len(snap2);
  assign start   = (state == ST_DISPATCH) && (cmd_q == SYS_WRITE) && (wr_len != 3'd0);

  rv_hostcall_resp_txq #(
    .TX_TIMEOUT(TX_TIMEOUT)
  ) u_txq (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data    (snap1),
    .len     (wr_len),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .done    (tx_done),
    .timeout (tx_tmo),
    .sent    (tx_sent)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:     if (cmd_wr) state_n = ST_DISPATCH;
      ST_DISPATCH: begin
        if (cmd_q == SYS_WRITE && wr_len != 3'd0) state_n = ST_SEND;
        else                                      state_n = ST_DONE;
      end
      ST_SEND:     if (tx_done) state_n = ST_DONE;
      ST_DONE:     state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    st       = '{ovr: ovr, tmo: tmo, exit_req: exit_req, busy: busy};
    rd_mux   = '0;
    case (adr)
      ADR_CMD:    rd_mux = cmd_q;
      ADR_ARG0:   rd_mux = arg0_q;
      ADR_ARG1:   rd_mux = arg1_q;
      ADR_ARG2:   rd_mux = arg2_q;
      ADR_STATUS: rd_mux = {28'd0, st};
      ADR_RET:    rd_mux = ret_q;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy       <= 1'b0;
      rdata     <= '0;
      cmd_q     <= '0;
      arg0_q    <= '0;
      arg1_q    <= '0;
      arg2_q    <= '0;
      snap0     <= '0;
      snap1     <= '0;
      snap2     <= '0;
      ret_q     <= '0;
      ovr       <= 1'b0;
      tmo       <= 1'b0;
      exit_req  <= 1'b0;
      exit_code <= '0;
    end else begin
      rdy   <= cs;
      rdata <= rd_en ? rd_mux : '0;

      if (wr_en && adr == ADR_ARG0) arg0_q <= apply_be(arg0_q, wdata, we);
      if (wr_en && adr == ADR_ARG1) arg1_q <= apply_be(arg1_q, wdata, we);
      if (wr_en && adr == ADR_ARG2) arg2_q <= apply_be(arg2_q, wdata, we);

      // the call works on a snapshot so later ARG writes cannot disturb it
      if (cmd_wr && !busy) begin
        cmd_q <= wdata;
        snap0 <= arg0_q;
        snap1 <= arg1_q;
        snap2 <= arg2_q;
      end

      // a new event in the same cycle as a STATUS read survives the clear
      ovr <= (cmd_wr && busy) || (ovr && !stat_rd);
      tmo <= (state == ST_SEND && tx_tmo) || (tmo && !stat_rd);

      if (state == ST_DISPATCH) begin
        if (cmd_q == SYS_EXIT) begin
          exit_code <= snap0;
          exit_req  <= 1'b1;
          ret_q     <= '0;
        end else if (cmd_q == SYS_WRITE) begin
          if (wr_len == 3'd0) ret_q <= '0;
        end else begin
          ret_q <= ENOSYS_RET;
        end
      end

      if (state == ST_SEND && tx_done) ret_q <= {29'd0, tx_sent};
    end
  end

endmodule

// File: tb/tb_rv_hostcall_resp.sv
// Self-checking bench for rv_hostcall_resp: register table, directed
// syscall sequences and randomized calls against a transaction-level model.
module tb_rv_hostcall_resp;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic [3:0]  we;
  logic [2:0]  adr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        exit_req;
  logic [31:0] exit_code;

  int tests = 0;
  int fails = 0;
  int rmode = 1;  // tx_ready: 0 low, 1 high, 2 random, 3 toggle

  logic [7:0] rx_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  rv_hostcall_resp #(.TX_TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .we       (we),
    .adr      (adr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rdy      (rdy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .exit_req (exit_req),
    .exit_code(exit_code)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (rmode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      2:       tx_ready = 1'($urandom % 2);
      default: tx_ready = ~tx_ready;
    endcase
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    cs = 1'b1; we = be; adr = a; wdata = d;
    tick();
    cs = 1'b0; we = 4'h0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    cs = 1'b1; we = 4'h0; adr = a;
    tick();
    cs = 1'b0;
    d = rdata;
  endtask

  task automatic set_mode(input int m);
    rmode = m;
    tx_ready = (m == 0) ? 1'b0 : 1'b1;
  endtask

  function automatic logic [31:0] be_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Sink: records accepted bytes and checks that stalled bytes are held.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && tx_valid) check("tx_hold", {24'd0, tx_data}, {24'd0, prev_data});
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  adr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[9];
  logic [31:0] r;
  logic [31:0] m_arg[3];
  logic [31:0] m_exit, m_cmd, num, d, snap1, exp_ret;
  logic [3:0]  be;
  logic        m_exitreq, ovr_do, ovr_seen, tmo_seen, pdone;
  int          n, exp_len;

  initial begin
    vt[0] = '{3'd0, 4'h0, 32'h0,         32'h0};
    vt[1] = '{3'd1, 4'hF, 32'h11223344,  32'h11223344};
    vt[2] = '{3'd2, 4'h5, 32'hAABBCCDD,  32'h00BB00DD};
    vt[3] = '{3'd2, 4'hA, 32'h55667788,  32'h55BB77DD};
    vt[4] = '{3'd3, 4'h8, 32'h12345678,  32'h12000000};
    vt[5] = '{3'd3, 4'h1, 32'h00000003,  32'h12000003};
    vt[6] = '{3'd4, 4'hF, 32'hFFFFFFFF,  32'h0};
    vt[7] = '{3'd5, 4'hF, 32'hFFFFFFFF,  32'h0};
    vt[8] = '{3'd6, 4'hF, 32'hFFFFFFFF,  32'h0};

    reset = 1'b1; cs = 1'b0; we = 4'h0; adr = 3'd0; wdata = 32'h0; tx_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_rdy", {31'd0, rdy}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_exit_req", {31'd0, exit_req}, 32'd0);
    check("rst_exit_code", exit_code, 32'h0);

    // register map and byte enables
    for (int i = 0; i < 9; i++) begin
      if (vt[i].we != 4'h0) bus_wr(vt[i].adr, vt[i].wdata, vt[i].we);
      bus_rd(vt[i].adr, r);
      check($sformatf("reg_vec%0d", i), r, vt[i].exp);
      check($sformatf("reg_rdy%0d", i), {31'd0, rdy}, 32'd1);
    end

    // exit call, cycle-by-cycle status
    bus_wr(3'd1, 32'd7, 4'hF);
    bus_wr(3'd0, 32'd93, 4'hF);
    bus_rd(3'd4, r); check("exit_st_dispatch", r, 32'h1);
    bus_rd(3'd4, r); check("exit_st_done", r, 32'h3);
    bus_rd(3'd4, r); check("exit_st_idle", r, 32'h2);
    bus_rd(3'd5, r); check("exit_ret", r, 32'h0);
    check("exit_code", exit_code, 32'd7);
    check("exit_req", {31'd0, exit_req}, 32'd1);
    bus_rd(3'd0, r); check("exit_cmd_rd", r, 32'd93);

    // write with ready held high
    set_mode(1);
    bus_wr(3'd2, 32'h64636261, 4'hF);
    bus_wr(3'd3, 32'd3, 4'hF);
    rx_q.delete();
    bus_wr(3'd0, 32'd64, 4'hF);
    tick(); check("wr_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h61});
    tick(); check("wr_b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h62});
    tick(); check("wr_b2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h63});
    tick(); check("wr_end_valid", {31'd0, tx_valid}, 32'd0);
    bus_rd(3'd4, r); check("wr_st_done", r, 32'h3);
    bus_rd(3'd4, r); check("wr_st_idle", r, 32'h2);
    bus_rd(3'd5, r); check("wr_ret", r, 32'd3);
    check("wr_rx_len", rx_q.size(), 32'd3);
    for (int i = 0; i < rx_q.size(); i++) check($sformatf("wr_rx%0d", i), {24'd0, rx_q[i]}, 32'h61 + i);

    // write with toggling backpressure
    rx_q.delete();
    set_mode(3);
    bus_wr(3'd0, 32'd64, 4'hF);
    repeat (20) tick();
    set_mode(1);
    bus_rd(3'd5, r); check("bp_ret", r, 32'd3);
    check("bp_rx_len", rx_q.size(), 32'd3);
    for (int i = 0; i < rx_q.size(); i++) check($sformatf("bp_rx%0d", i), {24'd0, rx_q[i]}, 32'h61 + i);

    // timeout with ready stuck low: TMO stalled cycles per byte
    rx_q.delete();
    set_mode(0);
    bus_wr(3'd3, 32'd2, 4'hF);
    bus_wr(3'd0, 32'd64, 4'hF);
    tick();
    check("tmo_valid_start", {31'd0, tx_valid}, 32'd1);
    repeat (TMO - 1) tick();
    check("tmo_valid_last", {31'd0, tx_valid}, 32'd1);
    tick();
    check("tmo_valid_drop", {31'd0, tx_valid}, 32'd0);
    repeat (3) tick();
    bus_rd(3'd4, r); check("tmo_st_set", r, 32'h6);
    bus_rd(3'd4, r); check("tmo_st_clr", r, 32'h2);
    bus_rd(3'd5, r); check("tmo_ret", r, 32'h0);
    check("tmo_rx_len", rx_q.size(), 32'd0);

    // unknown call
    bus_wr(3'd0, 32'd5, 4'hF);
    repeat (4) tick();
    bus_rd(3'd5, r); check("unk_ret", r, 32'hFFFFFFDA);
    bus_rd(3'd0, r); check("unk_cmd_rd", r, 32'd5);

    // overrun while a write is stalled; the exit must not run
    bus_wr(3'd1, 32'd99, 4'hF);
    bus_wr(3'd2, 32'h44434241, 4'hF);
    bus_wr(3'd3, 32'd4, 4'hF);
    bus_wr(3'd0, 32'd64, 4'hF);
    bus_wr(3'd0, 32'd93, 4'hF);
    bus_rd(3'd4, r); check("ovr_st", r, 32'hB);
    repeat (15) tick();
    bus_rd(3'd5, r); check("ovr_ret", r, 32'h0);
    check("ovr_exit_code", exit_code, 32'd7);
    bus_rd(3'd0, r); check("ovr_cmd_rd", r, 32'd64);
    bus_rd(3'd4, r); check("ovr_st_tmo", r, 32'h6);
    bus_rd(3'd4, r); check("ovr_st_clr", r, 32'h2);

    // CMD write landing in the DONE cycle is an overrun
    bus_wr(3'd0, 32'd5, 4'hF);
    tick();
    bus_wr(3'd0, 32'd93, 4'hF);
    bus_rd(3'd4, r); check("done_ovr_st", r, 32'hA);
    bus_rd(3'd5, r); check("done_ovr_ret", r, 32'hFFFFFFDA);
    check("done_ovr_exit_code", exit_code, 32'd7);

    // reset in the middle of SEND
    set_mode(1);
    rx_q.delete();
    bus_wr(3'd2, 32'h34333231, 4'hF);
    bus_wr(3'd0, 32'd64, 4'hF);
    tick();
    tick();
    set_mode(0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_exit_req", {31'd0, exit_req}, 32'd0);
    check("mid_rst_exit_code", exit_code, 32'h0);
    check("mid_rst_rdy", {31'd0, rdy}, 32'd0);
    repeat (10) tick();
    check("mid_rst_rx_len", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("mid_rst_rx0", {24'd0, rx_q[0]}, 32'h31);
    bus_rd(3'd4, r); check("mid_rst_st", r, 32'h0);
    bus_rd(3'd2, r); check("mid_rst_arg1", r, 32'h0);

    // randomized calls against a transaction-level model
    m_arg[0] = 32'h0; m_arg[1] = 32'h0; m_arg[2] = 32'h0;
    m_exit = 32'h0; m_exitreq = 1'b0;
    for (int c = 0; c < 40; c++) begin
      for (int a = 0; a < 3; a++) begin
        if ($urandom % 2 == 0) begin
          be = 4'($urandom_range(1, 15));
          d  = $urandom;
          if (a == 2 && $urandom % 4 != 0) d = $urandom_range(0, 6);
          bus_wr(3'(a + 1), d, be);
          m_arg[a] = be_merge(m_arg[a], d, be);
        end
      end
      case ($urandom % 4)
        0:       num = 32'd93;
        1, 2:    num = 32'd64;
        default: begin
          num = $urandom;
          if (num == 32'd93 || num == 32'd64) num = 32'd5;
        end
      endcase
      set_mode($urandom % 3);
      n     = (m_arg[2] > 32'd4) ? 4 : int'(m_arg[2]);
      snap1 = m_arg[1];
      m_cmd = num;
      rx_q.delete();
      bus_wr(3'd0, num, 4'($urandom_range(1, 15)));
      ovr_do = ($urandom % 3 == 0);
      if (ovr_do) bus_wr(3'd0, 32'd93, 4'hF);
      ovr_seen = 1'b0; tmo_seen = 1'b0; pdone = 1'b0;
      for (int p = 0; p < 200 && !pdone; p++) begin
        bus_rd(3'd4, r);
        ovr_seen |= r[3];
        tmo_seen |= r[2];
        if (!r[0]) pdone = 1'b1;
      end
      check($sformatf("rnd%0d_idle", c), {31'd0, pdone}, 32'd1);
      check($sformatf("rnd%0d_ovr", c), {31'd0, ovr_seen}, {31'd0, ovr_do});

      if (num == 32'd93) begin
        m_exit = m_arg[0]; m_exitreq = 1'b1;
        exp_ret = 32'h0; exp_len = 0;
        check($sformatf("rnd%0d_tmo", c), {31'd0, tmo_seen}, 32'd0);
      end else if (num == 32'd64) begin
        if (n == 0 || rmode == 0) exp_len = 0;
        else if (rmode == 1)      exp_len = n;
        else                      exp_len = tmo_seen ? rx_q.size() : n;
        if (n == 0 || rmode == 1) check($sformatf("rnd%0d_tmo", c), {31'd0, tmo_seen}, 32'd0);
        else if (rmode == 0)      check($sformatf("rnd%0d_tmo", c), {31'd0, tmo_seen}, 32'd1);
        else if (tmo_seen)        check($sformatf("rnd%0d_short", c), {31'd0, rx_q.size() < n}, 32'd1);
        exp_ret = exp_len;
      end else begin
        exp_ret = 32'hFFFFFFDA; exp_len = 0;
        check($sformatf("rnd%0d_tmo", c), {31'd0, tmo_seen}, 32'd0);
      end

      bus_rd(3'd5, r);
      check($sformatf("rnd%0d_ret", c), r, exp_ret);
      check($sformatf("rnd%0d_rx_len", c), rx_q.size(), exp_len);
      for (int i = 0; i < rx_q.size() && i < 4; i++)
        check($sformatf("rnd%0d_rx%0d", c, i), {24'd0, rx_q[i]}, {24'd0, snap1[8*i +: 8]});
      check($sformatf("rnd%0d_exit_code", c), exit_code, m_exit);
      check($sformatf("rnd%0d_exit_req", c), {31'd0, exit_req}, {31'd0, m_exitreq});
      bus_rd(3'd0, r);
      check($sformatf("rnd%0d_cmd_rd", c), r, m_cmd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
